// File: rtl/regfile_dump_pkg.sv
// Shared defaults and FSM encoding for the register-file dump engine.
package regfile_dump_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NUM_REGS = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/regfile_dump_obuf.sv
// Single-entry output register with valid/ready handshake; refills in the same
// cycle its current beat is taken so a steady stream has no bubbles.
module regfile_dump_obuf
    import regfile_dump_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_last,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] addr,
    output logic              last,
    output logic              free
);

    assign free = !valid || ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
            addr  <= '0;
            last  <= 1'b0;
        end else if (load && free) begin
            valid <= 1'b1;
            data  <= in_data;
            addr  <= in_addr;
            last  <= in_last;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_dump.sv
// Walks a register range through one RF read port and streams each word out
// with its index on a valid/ready interface.
//
//   state    | meaning
//   ST_IDLE  | waiting for start; range latched when it arrives
//   ST_RUN   | loading one beat per free output slot, cur advancing
//   ST_DRAIN | final beat loaded, waiting for the sink to take it
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [ADDR_W-1:0] dump_addr,
    output logic              dump_last
);

    state_t            state;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] last_q;
    logic [ADDR_W-1:0] cur_next;
    logic              free;
    logic              load;

    assign rf_addr  = cur;
    assign busy     = (state != ST_IDLE);
    assign load     = (state == ST_RUN);
    // Explicit wrap keeps the walk correct even if NUM_REGS < 2**ADDR_W.
    assign cur_next = (cur == ADDR_W'(NUM_REGS - 1)) ? '0 : cur + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            cur    <= '0;
            last_q <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cur    <= first_addr;
                        last_q <= last_addr;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (free) begin
                        if (cur == last_q) state <= ST_DRAIN;
                        else               cur   <= cur_next;
                    end
                end
                ST_DRAIN: begin
                    if (dump_valid && dump_ready) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    regfile_dump_obuf #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_obuf (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .in_data (rf_data),
        .in_addr (cur),
        .in_last (cur == last_q),
        .ready   (dump_ready),
        .valid   (dump_valid),
        .data    (dump_data),
        .addr    (dump_addr),
        .last    (dump_last),
        .free    (free)
    );

endmodule
